// File: rtl/ccip_rd_arb_pkg.sv
// Shared types and constants for the CCI-P c0 read-request arbiter.
package ccip_rd_arb_pkg;

  localparam int unsigned ADDR_W  = 42;
  localparam int unsigned MDATA_W = 16;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned STAT_W  = 32;

  typedef enum logic [1:0] {
    ARB_RUN,
    ARB_DRAIN,
    ARB_DRAINED
  } t_arb_state;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [MDATA_W-1:0] mdata;
  } t_c0_rd_req;

endpackage

// File: rtl/ccip_rr_pick.sv
// Combinational round-robin select: first set request at/after i_ptr, wrapping.
module ccip_rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] w_j;
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    j         = 0;
    w_j       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      j   = (32'(i_ptr) + off) % N;
      w_j = IDX_W'(j);
      if (!o_any_c && i_req[w_j]) begin
        o_grant_c[w_j] = 1'b1;
        o_idx_c        = w_j;
        o_any_c        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccip_rd_req_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read-request port among NUM_REQ requesters.
// Optional per-requester grant counters are built when CCIP_RD_ARB_STATS_EN is defined.
module ccip_rd_req_arbiter
  import ccip_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        c0_tx_valid,
  output logic [ADDR_W-1:0]           c0_tx_addr,
  output logic [MDATA_W-1:0]          c0_tx_mdata,
  input  logic                        c0_tx_alm_full,
  input  logic                        c0_rx_rsp_valid,
  input  logic [MDATA_W-1:0]          c0_rx_mdata,
  input  logic [DATA_W-1:0]           c0_rx_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        drain_req,
  output logic                        drain_done,
  output logic                        tag_err
`ifdef CCIP_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]   grant_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  t_arb_state         r_state;
  t_arb_state         w_state_nxt;
  logic [IDX_W-1:0]   r_rr;
  logic [CNT_W-1:0]   r_cnt [NUM_REQ];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_cnt_nz;
  logic [NUM_REQ-1:0] w_pick;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_grant_en;
  logic               w_grant_any;
  logic [NUM_REQ-1:0] w_grant;
  logic [ADDR_W-1:0]  w_grant_addr;
  logic               w_all_idle;
  logic [NUM_REQ-1:0] w_rsp_hit;
  logic [NUM_REQ-1:0] w_rsp_ok;
  logic               w_upper_zero;
  logic               w_rsp_bad;

  t_c0_rd_req         r_c0_req;
  logic               r_c0_valid;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_drain_done;
  logic               r_tag_err;

  // Eligibility and idle detection from the registered outstanding counters.
  always_comb begin
    w_elig     = '0;
    w_cnt_nz   = '0;
    w_all_idle = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i]   = req_valid[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
      w_cnt_nz[i] = (r_cnt[i] != '0);
      if (w_cnt_nz[i]) w_all_idle = 1'b0;
    end
  end

  ccip_rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .i_req     (w_elig),
    .i_ptr     (r_rr),
    .o_grant_c (w_pick),
    .o_idx_c   (w_pick_idx),
    .o_any_c   (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    case (r_state)
      ARB_RUN: begin
        w_grant_en = !c0_tx_alm_full;
        if (drain_req) w_state_nxt = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!drain_req)      w_state_nxt = ARB_RUN;
        else if (w_all_idle) w_state_nxt = ARB_DRAINED;
      end
      ARB_DRAINED: begin
        if (!drain_req) w_state_nxt = ARB_RUN;
      end
      default: w_state_nxt = ARB_RUN;
    endcase
  end

  assign w_grant     = w_grant_en ? w_pick : '0;
  assign w_grant_any = w_grant_en && w_pick_any;
  assign req_ready   = w_grant;

  always_comb begin
    w_grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_grant_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // A response is accepted only for an in-range tag whose requester has reads in flight.
  always_comb begin
    w_rsp_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp_hit[i] = c0_rx_rsp_valid && (c0_rx_mdata[IDX_W-1:0] == IDX_W'(i));
    end
    w_upper_zero = (c0_rx_mdata[MDATA_W-1:IDX_W] == '0);
    w_rsp_ok     = w_upper_zero ? (w_rsp_hit & w_cnt_nz) : '0;
    w_rsp_bad    = c0_rx_rsp_valid && (w_rsp_ok == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ARB_RUN;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr <= '0;
    end else if (w_grant_any) begin
      r_rr <= (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);
    end
  end

  // Grant and accepted response in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({w_grant[i], w_rsp_ok[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_c0_valid   <= 1'b0;
      r_c0_req     <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_drain_done <= 1'b0;
      r_tag_err    <= 1'b0;
    end else begin
      r_c0_valid <= w_grant_any;
      if (w_grant_any) begin
        r_c0_req <= '{addr: w_grant_addr, mdata: MDATA_W'(w_pick_idx)};
      end
      r_rsp_valid <= w_rsp_ok;
      if (|w_rsp_ok) r_rsp_data <= c0_rx_data;
      r_drain_done <= (w_state_nxt == ARB_DRAINED);
      if (w_rsp_bad) r_tag_err <= 1'b1;
    end
  end

  assign c0_tx_valid = r_c0_valid;
  assign c0_tx_addr  = r_c0_req.addr;
  assign c0_tx_mdata = r_c0_req.mdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign drain_done  = r_drain_done;
  assign tag_err     = r_tag_err;

`ifdef CCIP_RD_ARB_STATS_EN
  logic [STAT_W-1:0] r_gcnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) r_gcnt[i] <= r_gcnt[i] + STAT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign grant_cnt[g*STAT_W +: STAT_W] = r_gcnt[g];
  end
`endif

endmodule

// File: tb/tb_ccip_rd_req_arbiter.sv
// Scoreboard bench for ccip_rd_req_arbiter: directed stimulus pushes expected c0 requests
// and responses; a negedge monitor pops and compares them against the DUT outputs.
module tb_ccip_rd_req_arbiter;
  import ccip_rd_arb_pkg::*;

  localparam int unsigned NR = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NR-1:0]          req_valid;
  logic [NR*ADDR_W-1:0]   req_addr;
  logic [NR-1:0]          req_ready;
  logic                   c0_tx_valid;
  logic [ADDR_W-1:0]      c0_tx_addr;
  logic [MDATA_W-1:0]     c0_tx_mdata;
  logic                   c0_tx_alm_full;
  logic                   c0_rx_rsp_valid;
  logic [MDATA_W-1:0]     c0_rx_mdata;
  logic [DATA_W-1:0]      c0_rx_data;
  logic [NR-1:0]          rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   drain_req;
  logic                   drain_done;
  logic                   tag_err;
`ifdef CCIP_RD_ARB_STATS_EN
  logic [NR*STAT_W-1:0]   grant_cnt;
`endif

  ccip_rd_req_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .c0_tx_valid     (c0_tx_valid),
    .c0_tx_addr      (c0_tx_addr),
    .c0_tx_mdata     (c0_tx_mdata),
    .c0_tx_alm_full  (c0_tx_alm_full),
    .c0_rx_rsp_valid (c0_rx_rsp_valid),
    .c0_rx_mdata     (c0_rx_mdata),
    .c0_rx_data      (c0_rx_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .drain_req       (drain_req),
    .drain_done      (drain_done),
    .tag_err         (tag_err)
`ifdef CCIP_RD_ARB_STATS_EN
    ,
    .grant_cnt       (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [MDATA_W-1:0] mdata;
  } tx_t;

  typedef struct packed {
    logic [NR-1:0]     vec;
    logic [DATA_W-1:0] data;
  } rx_t;

  tx_t txq[$];
  rx_t rxq[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  exp_gcnt[NR];

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return 42'h155_5555_5500 + 42'(i * 16'h0101);
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every queued expectation must appear exactly one cycle after it was pushed.
  always @(negedge clk) begin : mon
    tx_t te;
    rx_t re;
    if (reset_n === 1'b1) begin
      if (c0_tx_valid !== 1'b0 || txq.size() != 0) begin
        if (txq.size() == 0) begin
          chk("tx_unexpected", 512'(c0_tx_valid), 512'(0));
        end else begin
          te = txq.pop_front();
          chk("tx_valid", 512'(c0_tx_valid), 512'(1));
          chk("tx_addr", 512'(c0_tx_addr), 512'(te.addr));
          chk("tx_mdata", 512'(c0_tx_mdata), 512'(te.mdata));
        end
      end
      if (rsp_valid !== '0 || rxq.size() != 0) begin
        if (rxq.size() == 0) begin
          chk("rsp_unexpected", 512'(rsp_valid), 512'(0));
        end else begin
          re = rxq.pop_front();
          chk("rsp_valid", 512'(rsp_valid), 512'(re.vec));
          chk("rsp_data", rsp_data, re.data);
        end
      end
    end
  end

  // One cycle: drive response inputs, check combinational grant, record expectations.
  task automatic step(input string nm, input logic [NR-1:0] exp_rdy,
                      input bit rv = 1'b0, input logic [15:0] md = 16'h0, input bit ok = 1'b0);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    c0_rx_rsp_valid = rv;
    c0_rx_mdata     = md;
    c0_rx_data      = d;
    #1;
    chk(nm, 512'(req_ready), 512'(exp_rdy));
    for (int i = 0; i < NR; i++) begin
      if (exp_rdy[i]) begin
        txq.push_back('{addr: addr_of(i), mdata: 16'(i)});
        exp_gcnt[i]++;
      end
    end
    if (rv && ok) rxq.push_back('{vec: 4'(1 << md[1:0]), data: d});
    @(negedge clk);
    c0_rx_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    req_valid       = '0;
    c0_tx_alm_full  = 1'b0;
    drain_req       = 1'b0;
    c0_rx_rsp_valid = 1'b0;
    c0_rx_mdata     = '0;
    repeat (2) @(negedge clk);
    txq.delete();
    rxq.delete();
    for (int i = 0; i < NR; i++) exp_gcnt[i] = 0;
    chk("rst_tx_valid", 512'(c0_tx_valid), 512'(0));
    chk("rst_tx_addr", 512'(c0_tx_addr), 512'(0));
    chk("rst_tx_mdata", 512'(c0_tx_mdata), 512'(0));
    chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
    chk("rst_rsp_data", rsp_data, 512'(0));
    chk("rst_drain_done", 512'(drain_done), 512'(0));
    chk("rst_tag_err", 512'(tag_err), 512'(0));
`ifdef CCIP_RD_ARB_STATS_EN
    chk("rst_grant_cnt", 512'(grant_cnt), 512'(0));
`endif
    reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int w;
    reset_n         = 1'b0;
    req_valid       = '0;
    c0_tx_alm_full  = 1'b0;
    drain_req       = 1'b0;
    c0_rx_rsp_valid = 1'b0;
    c0_rx_mdata     = '0;
    c0_rx_data      = '0;
    for (int i = 0; i < NR; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
    @(negedge clk);
    do_reset();

    // Requesters 0 and 2 alternate starting from rr=0.
    req_valid = 4'b0101;
    step("t1_g0", 4'b0001);
    step("t1_g2", 4'b0100);
    step("t1_g0b", 4'b0001);
    step("t1_g2b", 4'b0100);
    req_valid = '0;
    step("t1_r0", 4'b0000, 1'b1, 16'h0000, 1'b1);
    step("t1_r0b", 4'b0000, 1'b1, 16'h0000, 1'b1);
    step("t1_r2", 4'b0000, 1'b1, 16'h0002, 1'b1);
    step("t1_r2b", 4'b0000, 1'b1, 16'h0002, 1'b1);

    // Almost-full holds grants off; rr stays at 3.
    c0_tx_alm_full = 1'b1;
    req_valid      = 4'b1111;
    repeat (5) step("t2_almfull", 4'b0000);
    c0_tx_alm_full = 1'b0;
    step("t2_g3", 4'b1000);
    step("t2_g0", 4'b0001);
    req_valid = '0;
    step("t2_r3", 4'b0000, 1'b1, 16'h0003, 1'b1);
    step("t2_r0", 4'b0000, 1'b1, 16'h0000, 1'b1);

    // Outstanding cap for requester 1.
    req_valid = 4'b0010;
    repeat (8) step("t3_g1", 4'b0010);
    step("t3_cap", 4'b0000);
    step("t3_cap2", 4'b0000);
    step("t3_rsp", 4'b0000, 1'b1, 16'h0001, 1'b1);
    step("t3_g1_after", 4'b0010);
    step("t3_cap3", 4'b0000);
    req_valid = '0;
    repeat (8) step("t3_r1", 4'b0000, 1'b1, 16'h0001, 1'b1);

    // Response to an idle requester: dropped, flagged, no counter underflow.
    chk("t4_tag_err_clear", 512'(tag_err), 512'(0));
    step("t4_idle_rsp", 4'b0000, 1'b1, 16'h0002, 1'b0);
    chk("t4_tag_err_idle", 512'(tag_err), 512'(1));
    req_valid = 4'b0100;
    step("t4_g2", 4'b0100);
    req_valid = '0;
    step("t4_r2", 4'b0000, 1'b1, 16'h0002, 1'b1);
    chk("t4_tag_err_sticky", 512'(tag_err), 512'(1));
    do_reset();

    step("t4_mdata7", 4'b0000, 1'b1, 16'h0007, 1'b0);
    chk("t4_tag_err_mdata7", 512'(tag_err), 512'(1));
    do_reset();

    req_valid = 4'b0001;
    step("t4_g0", 4'b0001);
    req_valid = '0;
    step("t4_upper", 4'b0000, 1'b1, 16'h0100, 1'b0);
    chk("t4_tag_err_upper", 512'(tag_err), 512'(1));
    step("t4_r0", 4'b0000, 1'b1, 16'h0000, 1'b1);
    do_reset();

    // Reset with a read in flight; the late response is illegal.
    req_valid = 4'b0001;
    step("t4_g0_pre", 4'b0001);
    do_reset();
    step("t4_late", 4'b0000, 1'b1, 16'h0000, 1'b0);
    chk("t4_tag_err_late", 512'(tag_err), 512'(1));
    do_reset();

    // Drain with three reads outstanding.
    req_valid = 4'b0111;
    step("t5_g0", 4'b0001);
    step("t5_g1", 4'b0010);
    step("t5_g2", 4'b0100);
    req_valid = '0;
    drain_req = 1'b1;
    step("t5_drain_enter", 4'b0000);
    req_valid = 4'b1111;
    step("t5_blocked", 4'b0000);
    step("t5_r0", 4'b0000, 1'b1, 16'h0000, 1'b1);
    step("t5_r1", 4'b0000, 1'b1, 16'h0001, 1'b1);
    chk("t5_not_done", 512'(drain_done), 512'(0));
    step("t5_r2", 4'b0000, 1'b1, 16'h0002, 1'b1);
    w = 0;
    while (drain_done !== 1'b1 && w < 3) begin
      step("t5_wait", 4'b0000);
      w++;
    end
    chk("t5_drain_done", 512'(drain_done), 512'(1));
    drain_req = 1'b0;
    step("t5_undrain", 4'b0000);
    chk("t5_done_clear", 512'(drain_done), 512'(0));
    step("t5_g3", 4'b1000);
    req_valid = '0;
    step("t5_r3", 4'b0000, 1'b1, 16'h0003, 1'b1);

    // Grant and response to the same requester in one cycle keep out_cnt fixed.
    req_valid = 4'b0001;
    step("t6_g0", 4'b0001);
    repeat (8) step("t6_pair", 4'b0001, 1'b1, 16'h0000, 1'b1);
    repeat (7) step("t6_fill", 4'b0001);
    step("t6_full", 4'b0000);
    req_valid = '0;
    repeat (8) step("t6_r0", 4'b0000, 1'b1, 16'h0000, 1'b1);
`ifdef CCIP_RD_ARB_STATS_EN
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("t6_grant_cnt%0d", i), 512'(grant_cnt[i*STAT_W +: STAT_W]), 512'(exp_gcnt[i]));
    end
`endif

    step("end_idle", 4'b0000);
    step("end_idle2", 4'b0000);
    chk("end_txq_empty", 512'(txq.size()), 512'(0));
    chk("end_rxq_empty", 512'(rxq.size()), 512'(0));
    chk("end_tag_err", 512'(tag_err), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
